// File: rtl/adc_spi_reader.sv
// adc_spi_reader: periodic SPI master for a 12-bit serial ADC
// (ADC128S022-style framing: 16 SCLK per frame, 4 leading zeros, then
// 12 data bits MSB first).
//
// Handshake: adc_valid is a one-clk strobe with no back-pressure; adc_dout
// is valid on the cycle adc_valid is high and holds its value until the
// next strobe or reset.
//
// Build option: define ADC_AVG_EN to average four consecutive frames per
// adc_valid strobe. Without it, every frame produces a strobe.
module adc_spi_reader #(
  parameter int          CLK_DIV       = 4,
  parameter int          SAMPLE_PERIOD = 50000,
  parameter logic [2:0]  CHANNEL       = 3'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        adc_miso,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_mosi,
  output logic [11:0] adc_dout,
  output logic        adc_valid,
  output logic        busy
);

  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] DIV_LAST    = DW'(CLK_DIV - 1);
  localparam logic [15:0]   TX_WORD     = {2'b00, CHANNEL, 11'b0};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [PW-1:0]   period_cnt;
  logic            start_tick;
  logic [DW-1:0]   div_cnt;
  logic            div_done;
  logic            phase;      // 0: sclk low half of a bit, 1: high half
  logic [3:0]      bit_cnt;
  logic [15:0]     tx_sr;
  // Only the last 12 bits shifted in are kept: the 4 leading bits of the
  // frame fall off the top, which discards them without extra logic.
  logic [11:0]     rx_sr;

  assign start_tick = enable && (period_cnt == PERIOD_LAST);
  assign div_done   = (div_cnt == DIV_LAST);
  assign adc_mosi   = tx_sr[15];

  // Free-running sample-period counter, held at zero while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (!enable) begin
      period_cnt <= '0;
    end else if (period_cnt == PERIOD_LAST) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state and pin decode; a start tick outside IDLE is ignored.
  always_comb begin
    state_next = state;
    adc_cs_n   = 1'b1;
    adc_sclk   = 1'b1;
    busy       = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start_tick) state_next = ST_SETUP;
      end
      ST_SETUP: begin
        adc_cs_n = 1'b0;
        if (div_done) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        adc_cs_n = 1'b0;
        adc_sclk = phase;
        if (div_done && phase && (bit_cnt == 4'd15)) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        adc_cs_n = 1'b0;
        if (div_done) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Bit timing and shift registers: mosi advances on sclk falls, miso is
  // captured on the clk edge that raises sclk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      phase   <= 1'b0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          div_cnt <= '0;
          phase   <= 1'b0;
          bit_cnt <= '0;
          if (start_tick) tx_sr <= TX_WORD;
        end
        ST_SETUP, ST_HOLD: begin
          div_cnt <= div_done ? '0 : div_cnt + 1'b1;
        end
        ST_SHIFT: begin
          if (div_done) begin
            div_cnt <= '0;
            if (!phase) begin
              phase <= 1'b1;
              rx_sr <= {rx_sr[10:0], adc_miso};
            end else begin
              phase <= 1'b0;
              if (bit_cnt != 4'd15) begin
                bit_cnt <= bit_cnt + 1'b1;
                tx_sr   <= {tx_sr[14:0], 1'b0};
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          div_cnt <= '0;
        end
      endcase
    end
  end

`ifdef ADC_AVG_EN
  logic [13:0] avg_acc;
  logic [1:0]  avg_cnt;
  logic [13:0] avg_sum;

  assign avg_sum = avg_acc + {2'b00, rx_sr};

  // Accumulate four frames, publish the truncated mean on the fourth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adc_dout  <= '0;
      adc_valid <= 1'b0;
      avg_acc   <= '0;
      avg_cnt   <= '0;
    end else begin
      adc_valid <= 1'b0;
      if (state == ST_DONE) begin
        if (avg_cnt == 2'd3) begin
          adc_dout  <= avg_sum[13:2];
          adc_valid <= 1'b1;
          avg_acc   <= '0;
          avg_cnt   <= '0;
        end else begin
          avg_acc <= avg_sum;
          avg_cnt <= avg_cnt + 1'b1;
        end
      end
    end
  end
`else
  // Publish each completed frame's 12 data bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adc_dout  <= '0;
      adc_valid <= 1'b0;
    end else begin
      adc_valid <= 1'b0;
      if (state == ST_DONE) begin
        adc_dout  <= rx_sr;
        adc_valid <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_adc_spi_reader.sv
// tb_adc_spi_reader: drives adc_spi_reader with a behavioural ADC slave and
// checks frame shape, control word, sample data and valid timing against a
// frame-level reference model.
module tb_adc_spi_reader;

  localparam int         CLK_DIV       = 2;
  localparam int         SAMPLE_PERIOD = 100;
  localparam logic [2:0] CHANNEL       = 3'd5;
  localparam int         CS_LOW_CLKS   = 34 * CLK_DIV;
  localparam logic [15:0] TX_EXP       = {2'b00, CHANNEL, 11'b0};

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        adc_miso;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        adc_mosi;
  logic [11:0] adc_dout;
  logic        adc_valid;
  logic        busy;

  adc_spi_reader #(
    .CLK_DIV      (CLK_DIV),
    .SAMPLE_PERIOD(SAMPLE_PERIOD),
    .CHANNEL      (CHANNEL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .adc_miso (adc_miso),
    .adc_cs_n (adc_cs_n),
    .adc_sclk (adc_sclk),
    .adc_mosi (adc_mosi),
    .adc_dout (adc_dout),
    .adc_valid(adc_valid),
    .busy     (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // ---------------- ADC slave model + scoreboard ----------------
`ifdef ADC_AVG_EN
  logic [15:0] forced_q[$] = '{16'h0DDE, 16'h0DF8, 16'h0E0B, 16'h0E29, 16'h0DE0, 16'hFFFF};
`else
  logic [15:0] forced_q[$] = '{16'h0DE0, 16'hFFFF, 16'h0DDE, 16'h0DF8, 16'h0E0B, 16'h0E29};
`endif
  logic [11:0] exp_q[$];
  logic [15:0] adc_word;
  logic [15:0] mosi_cap;
  logic [11:0] last_dout = '0;
  logic        prev_cs_n = 1'b1;
  logic        prev_sclk = 1'b1;
  logic        prev_valid = 1'b0;
  logic        in_frame = 1'b0;
  logic        last_start_valid = 1'b0;
  int          bit_idx = 0;
  int          cs_low = 0;
  int          rises = 0;
  int          cyc = 0;
  int          last_start = 0;
  int          cs_rise_cyc = 0;
  int          frames_started = 0;
  int          frames_done = 0;
  int          valids = 0;
  int          pushes = 0;
  int          acc = 0;
  int          acc_n = 0;

  // Sampled on the falling clk edge, away from the DUT's active edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      in_frame         = 1'b0;
      last_start_valid = 1'b0;
      acc              = 0;
      acc_n            = 0;
      last_dout        = '0;
      prev_cs_n        = 1'b1;
      prev_sclk        = 1'b1;
      prev_valid       = 1'b0;
      adc_miso         = 1'b0;
    end else begin
      if (!enable) last_start_valid = 1'b0;

      if (prev_cs_n && !adc_cs_n) begin
        frames_started++;
        in_frame = 1'b1;
        cs_low   = 0;
        rises    = 0;
        bit_idx  = 0;
        mosi_cap = '0;
        adc_word = (forced_q.size() != 0) ? forced_q.pop_front() : 16'($urandom);
        check("busy_in_frame", busy, 1);
        check("dout_hold", adc_dout, last_dout);
        if (last_start_valid) check("frame_period", cyc - last_start, SAMPLE_PERIOD);
        last_start       = cyc;
        last_start_valid = enable;
      end

      if (!adc_cs_n) begin
        cs_low++;
        if (!prev_sclk && adc_sclk) begin
          rises++;
          mosi_cap = {mosi_cap[14:0], adc_mosi};
        end
        if (prev_sclk && !adc_sclk && bit_idx < 16) begin
          adc_miso = adc_word[15 - bit_idx];
          bit_idx++;
        end
      end

      if (!prev_cs_n && adc_cs_n && in_frame) begin
        in_frame    = 1'b0;
        cs_rise_cyc = cyc;
        frames_done++;
        check("cs_low_clks", cs_low, CS_LOW_CLKS);
        check("sclk_rises", rises, 16);
        check("mosi_word", mosi_cap, TX_EXP);
`ifdef ADC_AVG_EN
        acc   = acc + int'(adc_word[11:0]);
        acc_n = acc_n + 1;
        if (acc_n == 4) begin
          exp_q.push_back(12'(acc / 4));
          pushes++;
          acc   = 0;
          acc_n = 0;
        end
`else
        exp_q.push_back(adc_word[11:0]);
        pushes++;
`endif
      end

      if (adc_valid) begin
        valids++;
        check("valid_width", prev_valid, 0);
        check("valid_latency", cyc - cs_rise_cyc, 1);
        check("busy_after_frame", busy, 0);
        check("exp_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          last_dout = exp_q.pop_front();
          check("adc_dout", adc_dout, last_dout);
        end
      end

      prev_cs_n  = adc_cs_n;
      prev_sclk  = adc_sclk;
      prev_valid = adc_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_frames(input int n);
    int target;
    int budget;
    target = frames_done + n;
    budget = (n + 1) * SAMPLE_PERIOD * 2;
    while (frames_done < target && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    check("wait_frames_timeout", frames_done >= target, 1);
  endtask

  task automatic wait_rises(input int k);
    int budget;
    budget = SAMPLE_PERIOD * 3;
    while (!(in_frame && rises >= k) && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    check("wait_rises_timeout", in_frame && rises >= k, 1);
  endtask

  task automatic check_idle_pins(input string tag);
    check({tag, "_cs_n"}, adc_cs_n, 1);
    check({tag, "_sclk"}, adc_sclk, 1);
    check({tag, "_dout"}, adc_dout, 0);
    check({tag, "_valid"}, adc_valid, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int fs;
    int fd;
    rst      = 1'b1;
    enable   = 1'b0;
    adc_miso = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_pins("reset");
    check("reset_mosi", adc_mosi, 0);
    rst = 1'b0;

    // Continuous sampling with directed then random ADC words.
    @(posedge clk);
    #1 enable = 1'b1;
    wait_frames(10);

    // Drop enable mid-frame: frame completes, then no further frames.
    wait_rises(5);
    @(posedge clk);
    #1 enable = 1'b0;
    fd = frames_done;
    repeat (3 * CS_LOW_CLKS) @(posedge clk);
    #1;
    check("enable_drop_frame_done", frames_done - fd, 1);
    fs = frames_started;
    repeat (500) @(posedge clk);
    #1;
    check("enable_drop_no_start", frames_started - fs, 0);
    check("enable_drop_cs_idle", adc_cs_n, 1);

    // Reset mid-frame after the 8th sclk rise.
    repeat ($urandom_range(1, 40)) @(posedge clk);
    #1 enable = 1'b1;
    wait_frames(2);
    wait_rises(8);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_idle_pins("midframe_rst");
    enable = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat ($urandom_range(1, 30)) @(posedge clk);
    #1 enable = 1'b1;
    wait_frames(8);

    // Drain and final bookkeeping.
    @(posedge clk);
    #1 enable = 1'b0;
    repeat (2 * SAMPLE_PERIOD) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    check("valid_count", valids, pushes);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
